// File: rtl/tlb_l2_arbiter_if.sv
// TLB entry layout shared with tlb_L2, plus the arbiter's requester/L2 bundle.
// The master side is the two refill paths and the L2; the slave side is the arbiter.
package tlb_l2_arbiter_pkg;
  typedef struct packed {
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    logic        e;
    logic        v0;
    logic        d0;
    logic [1:0]  mat0;
    logic [1:0]  plv0;
    logic [19:0] ppn0;
    logic        v1;
    logic        d1;
    logic [1:0]  mat1;
    logic [1:0]  plv1;
    logic [19:0] ppn1;
  } tlb_entry_t;
endpackage

interface tlb_l2_arbiter_if #(parameter int TLBIDLEN = 4);
  import tlb_l2_arbiter_pkg::*;

  logic                req0_valid;
  logic [18:0]         req0_vppn;
  logic [9:0]          req0_asid;
  logic                req0_ready;
  logic                req1_valid;
  logic [18:0]         req1_vppn;
  logic [9:0]          req1_asid;
  logic                req1_ready;

  logic                resp0_valid;
  logic                resp0_found;
  logic [TLBIDLEN-1:0] resp0_index;
  tlb_entry_t          resp0_entry;
  logic                resp1_valid;
  logic                resp1_found;
  logic [TLBIDLEN-1:0] resp1_index;
  tlb_entry_t          resp1_entry;

  logic                maint_valid;

  logic                l2_valid;
  logic [18:0]         l2_vppn;
  logic [9:0]          l2_asid;
  logic                l2_found;
  logic [TLBIDLEN-1:0] l2_index;
  tlb_entry_t          l2_entry;

  modport slave (
    input  req0_valid, req0_vppn, req0_asid,
    input  req1_valid, req1_vppn, req1_asid,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_found, resp0_index, resp0_entry,
    output resp1_valid, resp1_found, resp1_index, resp1_entry,
    input  maint_valid,
    output l2_valid, l2_vppn, l2_asid,
    input  l2_found, l2_index, l2_entry
  );

  modport master (
    output req0_valid, req0_vppn, req0_asid,
    output req1_valid, req1_vppn, req1_asid,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_found, resp0_index, resp0_entry,
    input  resp1_valid, resp1_found, resp1_index, resp1_entry,
    output maint_valid,
    input  l2_valid, l2_vppn, l2_asid,
    output l2_found, l2_index, l2_entry
  );
endinterface

// File: rtl/tlb_l2_arbiter.sv
// Round-robin share of the L2 TLB lookup port between fetch and load/store; 3 cycles handshake to resp pulse.
// Readys drop outside IDLE and during maintenance; maintenance aborts a lookup, which replays before new grants.
module tlb_l2_arbiter
  import tlb_l2_arbiter_pkg::*;
#(
  parameter int TLBIDLEN = 4
) (
  input  logic           clk,
  input  logic           reset,
  tlb_l2_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q;
  logic                pend_q;
  logic                rr_q;
  logic [18:0]         vppn_q;
  logic [9:0]          asid_q;

  logic                resp0_valid_q, resp1_valid_q;
  logic                resp0_found_q, resp1_found_q;
  logic [TLBIDLEN-1:0] resp0_index_q, resp1_index_q;
  tlb_entry_t          resp0_entry_q, resp1_entry_q;

  logic                ready0, ready1;
  logic                grant0, grant1;
  logic                lookup_vld;
  logic                abort;
  logic                complete;

  always_comb begin
    state_d    = state_q;
    ready0     = 1'b0;
    ready1     = 1'b0;
    grant0     = 1'b0;
    grant1     = 1'b0;
    lookup_vld = 1'b0;
    abort      = 1'b0;
    complete   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!bus.maint_valid) begin
          if (pend_q) begin
            state_d = S_LOOKUP;
          end else begin
            // Each ready looks only at the other port's valid, so a port
            // never sees its own valid fed back into its ready.
            ready0 = !bus.req1_valid || !rr_q;
            ready1 = !bus.req0_valid ||  rr_q;
            grant0 = bus.req0_valid && ready0;
            grant1 = bus.req1_valid && ready1;
            if (grant0 || grant1) state_d = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: begin
        lookup_vld = 1'b1;
        if (bus.maint_valid) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (bus.maint_valid) abort = 1'b1;
        else                 complete = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (reset) begin
      ready0     = 1'b0;
      ready1     = 1'b0;
      grant0     = 1'b0;
      grant1     = 1'b0;
      lookup_vld = 1'b0;
      abort      = 1'b0;
      complete   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      owner_q       <= 1'b0;
      pend_q        <= 1'b0;
      rr_q          <= 1'b0;
      vppn_q        <= '0;
      asid_q        <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_found_q <= 1'b0;
      resp1_found_q <= 1'b0;
      resp0_index_q <= '0;
      resp1_index_q <= '0;
      resp0_entry_q <= '0;
      resp1_entry_q <= '0;
    end else begin
      state_q       <= state_d;
      resp0_valid_q <= complete && !owner_q;
      resp1_valid_q <= complete &&  owner_q;

      if (grant0) begin
        owner_q <= 1'b0;
        vppn_q  <= bus.req0_vppn;
        asid_q  <= bus.req0_asid;
      end else if (grant1) begin
        owner_q <= 1'b1;
        vppn_q  <= bus.req1_vppn;
        asid_q  <= bus.req1_asid;
      end

      // An aborted lookup keeps owner/vppn_q/asid_q untouched for the replay.
      if (abort) pend_q <= 1'b1;

      if (complete) begin
        pend_q <= 1'b0;
        rr_q   <= !owner_q;
        if (!owner_q) begin
          resp0_found_q <= bus.l2_found;
          resp0_index_q <= bus.l2_index;
          resp0_entry_q <= bus.l2_entry;
        end else begin
          resp1_found_q <= bus.l2_found;
          resp1_index_q <= bus.l2_index;
          resp1_entry_q <= bus.l2_entry;
        end
      end
    end
  end

  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.l2_valid    = lookup_vld;
  assign bus.l2_vppn     = vppn_q;
  assign bus.l2_asid     = asid_q;
  assign bus.resp0_valid = resp0_valid_q;
  assign bus.resp0_found = resp0_found_q;
  assign bus.resp0_index = resp0_index_q;
  assign bus.resp0_entry = resp0_entry_q;
  assign bus.resp1_valid = resp1_valid_q;
  assign bus.resp1_found = resp1_found_q;
  assign bus.resp1_index = resp1_index_q;
  assign bus.resp1_entry = resp1_entry_q;

  a_one_grant: assert property (@(posedge clk) disable iff (reset) !(grant0 && grant1));
  a_one_resp:  assert property (@(posedge clk) disable iff (reset) !(resp0_valid_q && resp1_valid_q));
  a_no_grant_busy: assert property (@(posedge clk) disable iff (reset)
                                    (state_q != S_IDLE) |-> !(ready0 || ready1));

endmodule

// File: tb/tb_tlb_l2_arbiter.sv
// Directed scenarios for tlb_l2_arbiter against a one-cycle-latency L2 model.
module tb_tlb_l2_arbiter;
  import tlb_l2_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  logic        l2_hit = 1'b1;
  logic [3:0]  l2_idx = 4'd0;
  logic [19:0] l2_ppn = 20'd0;

  tlb_l2_arbiter_if #(.TLBIDLEN(4)) ifc ();

  tlb_l2_arbiter #(.TLBIDLEN(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  function automatic tlb_entry_t mk_entry(input logic [18:0] v, input logic [9:0] a,
                                          input logic [19:0] p);
    tlb_entry_t e;
    e      = '0;
    e.vppn = v;
    e.asid = a;
    e.ppn0 = p;
    e.v0   = 1'b1;
    return e;
  endfunction

  // L2 answers the cycle after l2_valid; otherwise it shows junk that must not be sampled.
  always @(posedge clk) begin
    if (ifc.l2_valid) begin
      ifc.l2_found <= l2_hit;
      ifc.l2_index <= l2_idx;
      ifc.l2_entry <= mk_entry(ifc.l2_vppn, ifc.l2_asid, l2_ppn);
    end else begin
      ifc.l2_found <= 1'b1;
      ifc.l2_index <= 4'hF;
      ifc.l2_entry <= '1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    ifc.req0_valid = 1'b1;
    step();
    step();
    n_checks++; if (ifc.req0_ready !== 1'b0) $display("FAIL rst_ready0: got %b want 0", ifc.req0_ready); else n_pass++;
    n_checks++; if (ifc.req1_ready !== 1'b0) $display("FAIL rst_ready1: got %b want 0", ifc.req1_ready); else n_pass++;
    n_checks++; if (ifc.l2_valid !== 1'b0) $display("FAIL rst_l2_valid: got %b want 0", ifc.l2_valid); else n_pass++;
    ifc.req0_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_checks++; if ({ifc.resp0_valid, ifc.resp1_valid} !== 2'b00) $display("FAIL rst_resp_valid: got %b want 00", {ifc.resp0_valid, ifc.resp1_valid}); else n_pass++;
    n_checks++; if ({ifc.resp0_found, ifc.resp1_found} !== 2'b00) $display("FAIL rst_resp_found: got %b want 00", {ifc.resp0_found, ifc.resp1_found}); else n_pass++;
    n_checks++; if ({ifc.resp0_index, ifc.resp1_index} !== 8'h00) $display("FAIL rst_resp_index: got %h want 00", {ifc.resp0_index, ifc.resp1_index}); else n_pass++;
    n_checks++; if ((ifc.resp0_entry | ifc.resp1_entry) !== '0) $display("FAIL rst_resp_entry: got %h want 0", ifc.resp0_entry | ifc.resp1_entry); else n_pass++;
    n_checks++; if ({ifc.l2_vppn, ifc.l2_asid} !== 29'd0) $display("FAIL rst_l2_addr: got %h want 0", {ifc.l2_vppn, ifc.l2_asid}); else n_pass++;
    n_checks++; if ({ifc.req0_ready, ifc.req1_ready} !== 2'b11) $display("FAIL rst_idle_readys: got %b want 11", {ifc.req0_ready, ifc.req1_ready}); else n_pass++;
  endtask

  task automatic test_single();
    l2_hit = 1'b1; l2_idx = 4'd7; l2_ppn = 20'hAAAAA;
    ifc.req0_valid = 1'b1; ifc.req0_vppn = 19'h12345; ifc.req0_asid = 10'd5;
    #1;
    n_checks++; if ({ifc.req0_ready, ifc.req1_ready} !== 2'b10) $display("FAIL single_readys: got %b want 10", {ifc.req0_ready, ifc.req1_ready}); else n_pass++;
    step();
    ifc.req0_valid = 1'b0;
    n_checks++; if (ifc.l2_valid !== 1'b1) $display("FAIL single_l2_valid: got %b want 1", ifc.l2_valid); else n_pass++;
    n_checks++; if ({ifc.l2_vppn, ifc.l2_asid} !== {19'h12345, 10'd5}) $display("FAIL single_l2_addr: got %h/%h want 12345/005", ifc.l2_vppn, ifc.l2_asid); else n_pass++;
    n_checks++; if (ifc.req0_ready !== 1'b0) $display("FAIL single_busy_ready: got %b want 0", ifc.req0_ready); else n_pass++;
    step();
    n_checks++; if ({ifc.l2_valid, ifc.resp0_valid} !== 2'b00) $display("FAIL single_t2: got %b want 00", {ifc.l2_valid, ifc.resp0_valid}); else n_pass++;
    step();
    n_checks++; if ({ifc.resp0_valid, ifc.resp1_valid} !== 2'b10) $display("FAIL single_t3_valid: got %b want 10", {ifc.resp0_valid, ifc.resp1_valid}); else n_pass++;
    n_checks++; if ({ifc.resp0_found, ifc.resp0_index} !== {1'b1, 4'd7}) $display("FAIL single_t3_data: got %b/%h want 1/7", ifc.resp0_found, ifc.resp0_index); else n_pass++;
    n_checks++; if (ifc.resp0_entry !== mk_entry(19'h12345, 10'd5, 20'hAAAAA)) $display("FAIL single_t3_entry: got %h", ifc.resp0_entry); else n_pass++;
    step();
    n_checks++; if ({ifc.resp0_valid, ifc.resp0_index} !== {1'b0, 4'd7}) $display("FAIL single_hold: got %b/%h want 0/7", ifc.resp0_valid, ifc.resp0_index); else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    l2_hit = 1'b1; l2_idx = 4'd3; l2_ppn = 20'h33333;
    ifc.req0_valid = 1'b1; ifc.req0_vppn = 19'h00A0A; ifc.req0_asid = 10'd1;
    ifc.req1_valid = 1'b1; ifc.req1_vppn = 19'h00B0B; ifc.req1_asid = 10'd2;
    #1;
    n_checks++; if ({ifc.req0_ready, ifc.req1_ready} !== 2'b10) $display("FAIL rr_t0_readys: got %b want 10", {ifc.req0_ready, ifc.req1_ready}); else n_pass++;
    step();
    ifc.req0_vppn = 19'h00C0C;
    n_checks++; if ({ifc.l2_vppn, ifc.l2_asid} !== {19'h00A0A, 10'd1}) $display("FAIL rr_t1_addr: got %h/%h want 00a0a/001", ifc.l2_vppn, ifc.l2_asid); else n_pass++;
    n_checks++; if ({ifc.req0_ready, ifc.req1_ready} !== 2'b00) $display("FAIL rr_t1_readys: got %b want 00", {ifc.req0_ready, ifc.req1_ready}); else n_pass++;
    step(); step();
    n_checks++; if ({ifc.resp0_valid, ifc.resp1_valid} !== 2'b10) $display("FAIL rr_t3_valid: got %b want 10", {ifc.resp0_valid, ifc.resp1_valid}); else n_pass++;
    n_checks++; if (ifc.resp0_entry.vppn !== 19'h00A0A) $display("FAIL rr_t3_vppn: got %h want 00a0a", ifc.resp0_entry.vppn); else n_pass++;
    n_checks++; if ({ifc.req0_ready, ifc.req1_ready} !== 2'b01) $display("FAIL rr_t3_readys: got %b want 01", {ifc.req0_ready, ifc.req1_ready}); else n_pass++;
    step();
    n_checks++; if ({ifc.l2_vppn, ifc.l2_asid} !== {19'h00B0B, 10'd2}) $display("FAIL rr_t4_addr: got %h/%h want 00b0b/002", ifc.l2_vppn, ifc.l2_asid); else n_pass++;
    step(); step();
    n_checks++; if ({ifc.resp0_valid, ifc.resp1_valid} !== 2'b01) $display("FAIL rr_t6_valid: got %b want 01", {ifc.resp0_valid, ifc.resp1_valid}); else n_pass++;
    n_checks++; if ({ifc.resp1_found, ifc.resp1_index, ifc.resp1_entry.vppn} !== {1'b1, 4'd3, 19'h00B0B}) $display("FAIL rr_t6_data: got %b/%h/%h want 1/3/00b0b", ifc.resp1_found, ifc.resp1_index, ifc.resp1_entry.vppn); else n_pass++;
    n_checks++; if ({ifc.req0_ready, ifc.req1_ready} !== 2'b10) $display("FAIL rr_t6_readys: got %b want 10", {ifc.req0_ready, ifc.req1_ready}); else n_pass++;
    ifc.req1_valid = 1'b0;
    step();
    ifc.req0_valid = 1'b0;
    n_checks++; if (ifc.l2_vppn !== 19'h00C0C) $display("FAIL rr_t7_vppn: got %h want 00c0c", ifc.l2_vppn); else n_pass++;
    step(); step();
    n_checks++; if ({ifc.resp0_valid, ifc.resp0_entry.vppn} !== {1'b1, 19'h00C0C}) $display("FAIL rr_t9_resp0: got %b/%h want 1/00c0c", ifc.resp0_valid, ifc.resp0_entry.vppn); else n_pass++;
  endtask

  task automatic test_miss();
    l2_hit = 1'b0; l2_idx = 4'd9; l2_ppn = 20'h55555;
    ifc.req1_valid = 1'b1; ifc.req1_vppn = 19'h7FFFF; ifc.req1_asid = 10'h3FF;
    #1;
    n_checks++; if ({ifc.req0_ready, ifc.req1_ready} !== 2'b01) $display("FAIL miss_readys: got %b want 01", {ifc.req0_ready, ifc.req1_ready}); else n_pass++;
    step();
    ifc.req1_valid = 1'b0;
    n_checks++; if ({ifc.l2_vppn, ifc.l2_asid} !== {19'h7FFFF, 10'h3FF}) $display("FAIL miss_addr: got %h/%h want 7ffff/3ff", ifc.l2_vppn, ifc.l2_asid); else n_pass++;
    step(); step();
    n_checks++; if ({ifc.resp1_valid, ifc.resp1_found, ifc.resp1_index} !== {1'b1, 1'b0, 4'd9}) $display("FAIL miss_resp1: got %b/%b/%h want 1/0/9", ifc.resp1_valid, ifc.resp1_found, ifc.resp1_index); else n_pass++;
    n_checks++; if (ifc.resp1_entry !== mk_entry(19'h7FFFF, 10'h3FF, 20'h55555)) $display("FAIL miss_entry: got %h", ifc.resp1_entry); else n_pass++;
    n_checks++; if ({ifc.resp0_valid, ifc.resp0_index} !== {1'b0, 4'd3}) $display("FAIL miss_resp0_untouched: got %b/%h want 0/3", ifc.resp0_valid, ifc.resp0_index); else n_pass++;
  endtask

  task automatic test_maint_lookup();
    l2_hit = 1'b1; l2_idx = 4'd6; l2_ppn = 20'h12121;
    ifc.req0_valid = 1'b1; ifc.req0_vppn = 19'h00ABC; ifc.req0_asid = 10'd7;
    step();
    ifc.req0_valid = 1'b0;
    ifc.maint_valid = 1'b1;
    ifc.req1_valid = 1'b1; ifc.req1_vppn = 19'h00DEF; ifc.req1_asid = 10'd8;
    #1;
    n_checks++; if ({ifc.l2_valid, ifc.req1_ready} !== 2'b10) $display("FAIL ml_t1: got %b want 10", {ifc.l2_valid, ifc.req1_ready}); else n_pass++;
    step();
    n_checks++; if ({ifc.l2_valid, ifc.req0_ready, ifc.req1_ready, ifc.resp0_valid} !== 4'b0000) $display("FAIL ml_t2: got %b want 0000", {ifc.l2_valid, ifc.req0_ready, ifc.req1_ready, ifc.resp0_valid}); else n_pass++;
    step();
    ifc.maint_valid = 1'b0;
    #1;
    n_checks++; if ({ifc.req1_ready, ifc.resp0_valid} !== 2'b00) $display("FAIL ml_t3_replay_first: got %b want 00", {ifc.req1_ready, ifc.resp0_valid}); else n_pass++;
    step();
    n_checks++; if ({ifc.l2_valid, ifc.l2_vppn, ifc.l2_asid} !== {1'b1, 19'h00ABC, 10'd7}) $display("FAIL ml_t4_replay: got %b/%h/%h want 1/00abc/007", ifc.l2_valid, ifc.l2_vppn, ifc.l2_asid); else n_pass++;
    step();
    n_checks++; if (ifc.resp0_valid !== 1'b0) $display("FAIL ml_t5_early: got %b want 0", ifc.resp0_valid); else n_pass++;
    step();
    n_checks++; if ({ifc.resp0_valid, ifc.resp1_valid, ifc.resp0_index} !== {2'b10, 4'd6}) $display("FAIL ml_t6_resp: got %b%b/%h want 10/6", ifc.resp0_valid, ifc.resp1_valid, ifc.resp0_index); else n_pass++;
    n_checks++; if (ifc.resp0_entry.vppn !== 19'h00ABC) $display("FAIL ml_t6_vppn: got %h want 00abc", ifc.resp0_entry.vppn); else n_pass++;
    n_checks++; if (ifc.req1_ready !== 1'b1) $display("FAIL ml_t6_req1_ready: got %b want 1", ifc.req1_ready); else n_pass++;
    step();
    ifc.req1_valid = 1'b0;
    step(); step();
    n_checks++; if ({ifc.resp1_valid, ifc.resp1_entry.vppn} !== {1'b1, 19'h00DEF}) $display("FAIL ml_t9_resp1: got %b/%h want 1/00def", ifc.resp1_valid, ifc.resp1_entry.vppn); else n_pass++;
  endtask

  task automatic test_maint_resp();
    l2_hit = 1'b1; l2_idx = 4'd2; l2_ppn = 20'h0F0F0;
    ifc.req0_valid = 1'b1; ifc.req0_vppn = 19'h11111; ifc.req0_asid = 10'h155;
    step();
    ifc.req0_valid = 1'b0;
    step();
    ifc.maint_valid = 1'b1;
    l2_idx = 4'd5; l2_ppn = 20'h0BEEF;
    step();
    ifc.maint_valid = 1'b0;
    n_checks++; if ({ifc.resp0_valid, ifc.resp0_index} !== {1'b0, 4'd6}) $display("FAIL mr_t3_discard: got %b/%h want 0/6", ifc.resp0_valid, ifc.resp0_index); else n_pass++;
    n_checks++; if (ifc.resp0_entry.ppn0 !== 20'h12121) $display("FAIL mr_t3_entry_held: got %h want 12121", ifc.resp0_entry.ppn0); else n_pass++;
    step();
    n_checks++; if ({ifc.l2_valid, ifc.l2_vppn} !== {1'b1, 19'h11111}) $display("FAIL mr_t4_replay: got %b/%h want 1/11111", ifc.l2_valid, ifc.l2_vppn); else n_pass++;
    step(); step();
    n_checks++; if ({ifc.resp0_valid, ifc.resp0_found, ifc.resp0_index} !== {2'b11, 4'd5}) $display("FAIL mr_t6_resp: got %b/%b/%h want 1/1/5", ifc.resp0_valid, ifc.resp0_found, ifc.resp0_index); else n_pass++;
    n_checks++; if (ifc.resp0_entry !== mk_entry(19'h11111, 10'h155, 20'h0BEEF)) $display("FAIL mr_t6_entry: got %h", ifc.resp0_entry); else n_pass++;
  endtask

  task automatic test_reset_mid();
    l2_hit = 1'b1; l2_idx = 4'd4; l2_ppn = 20'h44444;
    ifc.req0_valid = 1'b1; ifc.req0_vppn = 19'h22222; ifc.req0_asid = 10'd3;
    step();
    ifc.req0_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    ifc.req1_valid = 1'b1; ifc.req1_vppn = 19'h33333; ifc.req1_asid = 10'd9;
    #1;
    n_checks++; if ({ifc.req1_ready, ifc.l2_valid, ifc.resp0_valid} !== 3'b000) $display("FAIL rm_in_reset: got %b want 000", {ifc.req1_ready, ifc.l2_valid, ifc.resp0_valid}); else n_pass++;
    n_checks++; if (ifc.resp0_index !== 4'd0) $display("FAIL rm_index_cleared: got %h want 0", ifc.resp0_index); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++; if ({ifc.req0_ready, ifc.req1_ready} !== 2'b11) $display("FAIL rm_release_readys: got %b want 11", {ifc.req0_ready, ifc.req1_ready}); else n_pass++;
    step();
    ifc.req1_valid = 1'b0;
    n_checks++; if ({ifc.l2_valid, ifc.l2_vppn} !== {1'b1, 19'h33333}) $display("FAIL rm_t4_lookup: got %b/%h want 1/33333", ifc.l2_valid, ifc.l2_vppn); else n_pass++;
    step();
    n_checks++; if (ifc.resp0_valid !== 1'b0) $display("FAIL rm_no_stale_resp0: got %b want 0", ifc.resp0_valid); else n_pass++;
    step();
    n_checks++; if ({ifc.resp0_valid, ifc.resp1_valid, ifc.resp1_index} !== {2'b01, 4'd4}) $display("FAIL rm_t6_resp1: got %b%b/%h want 01/4", ifc.resp0_valid, ifc.resp1_valid, ifc.resp1_index); else n_pass++;
  endtask

  initial begin
    ifc.req0_valid  = 1'b0;
    ifc.req0_vppn   = '0;
    ifc.req0_asid   = '0;
    ifc.req1_valid  = 1'b0;
    ifc.req1_vppn   = '0;
    ifc.req1_asid   = '0;
    ifc.maint_valid = 1'b0;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_miss();
    test_maint_lookup();
    test_maint_resp();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
